// File: rtl/rv32_pipe_controller.sv
// RV32I pipeline control: decodes the ID instruction into a control word held in an ID/EX register.
// Latency: instruction accepted at edge N drives its EX controls after edge N; pc_sel/flush are combinational.
// Backpressure: i_ex_stall holds ID/EX (ready=0); a load-use hazard drops ready and inserts a bubble.
//
// Ports: clk/rst (async active-high); i_inst_valid/i_inst/o_id_ready = ID handshake;
//        i_ex_stall = hold EX; i_br_eq/i_br_lt = EX comparator flags; o_pc_sel/o_flush =
//        redirect; o_* remaining = EX control word and register indices; o_illegal = undecodable.
module rv32_pipe_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int EN_JUMPS   = 1,
    parameter int EN_HAZARD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_inst_valid,
    input  logic [31:0]           i_inst,
    output logic                  o_id_ready,
    input  logic                  i_ex_stall,
    input  logic                  i_br_eq,
    input  logic                  i_br_lt,
    output logic                  o_ex_valid,
    output logic                  o_pc_sel,
    output logic                  o_flush,
    output logic [2:0]            o_imm_sel,
    output logic                  o_br_un,
    output logic                  o_a_sel,
    output logic                  o_b_sel,
    output logic [3:0]            o_alu_sel,
    output logic                  o_mem_rw,
    output logic                  o_reg_wen,
    output logic [1:0]            o_wb_sel,
    output logic [2:0]            o_mem_funct3,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic                  o_illegal
);
    localparam int REG_N = 1 << REG_ADDR_W;

    // ID field extraction
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f, rs1_f, rs2_f;
    assign opc   = i_inst[6:0];
    assign rd_f  = i_inst[11:7];
    assign f3    = i_inst[14:12];
    assign rs1_f = i_inst[19:15];
    assign rs2_f = i_inst[24:20];
    assign f7    = i_inst[31:25];

    // ID decode
    logic       d_illegal, d_load, d_branch, d_jump, d_a, d_b, d_mem_rw, d_wr, d_use1, d_use2;
    logic [2:0] d_imm;
    logic [3:0] d_alu;
    logic [1:0] d_wb;
    logic       d_reg_wen;
    int         rd_i, rs1_i, rs2_i;

    always_comb begin
        d_illegal = 1'b0;
        d_load    = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_a       = 1'b0;
        d_b       = 1'b1;
        d_mem_rw  = 1'b0;
        d_wr      = 1'b0;
        d_use1    = 1'b0;
        d_use2    = 1'b0;
        d_imm     = 3'd0;
        d_alu     = 4'd0;
        d_wb      = 2'd1;
        rd_i      = int'(rd_f);
        rs1_i     = int'(rs1_f);
        rs2_i     = int'(rs2_f);
        case (opc)
            7'b0110011, 7'b0010011: begin           // R-type / I-type ALU
                d_b    = (opc == 7'b0010011);
                d_wr   = 1'b1;
                d_use1 = 1'b1;
                d_use2 = (opc == 7'b0110011);
                case (f3)
                    3'd0: d_alu = (d_use2 && f7[5]) ? 4'd1 : 4'd0;
                    3'd1: d_alu = 4'd2;
                    3'd2: d_alu = 4'd3;
                    3'd3: d_alu = 4'd4;
                    3'd4: d_alu = 4'd5;
                    3'd5: d_alu = f7[5] ? 4'd7 : 4'd6;
                    3'd6: d_alu = 4'd8;
                    default: d_alu = 4'd9;
                endcase
                // funct7 only meaningful for R-type and immediate shifts
                if (d_use2)
                    d_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                else if (f3 == 3'd1)
                    d_illegal = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    d_illegal = !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'b0000011: begin                       // loads
                d_load    = 1'b1;
                d_wr      = 1'b1;
                d_use1    = 1'b1;
                d_wb      = 2'd0;
                d_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'b0100011: begin                       // stores
                d_mem_rw  = 1'b1;
                d_use1    = 1'b1;
                d_use2    = 1'b1;
                d_imm     = 3'd1;
                d_illegal = (f3 > 3'd2);
            end
            7'b1100011: begin                       // branches: ALU forms PC + imm
                d_branch  = 1'b1;
                d_a       = 1'b1;
                d_use1    = 1'b1;
                d_use2    = 1'b1;
                d_imm     = 3'd2;
                d_illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b1101111: begin                       // jal
                d_jump = 1'b1;
                d_a    = 1'b1;
                d_wr   = 1'b1;
                d_imm  = 3'd4;
                d_wb   = 2'd2;
                d_illegal = (EN_JUMPS == 0);
            end
            7'b1100111: begin                       // jalr
                d_jump = 1'b1;
                d_wr   = 1'b1;
                d_use1 = 1'b1;
                d_wb   = 2'd2;
                d_illegal = (EN_JUMPS == 0) || (f3 != 3'd0);
            end
            7'b0110111: begin                       // lui
                d_wr  = 1'b1;
                d_imm = 3'd3;
                d_alu = 4'd10;
                d_illegal = (EN_JUMPS == 0);
            end
            7'b0010111: begin                       // auipc
                d_wr  = 1'b1;
                d_a   = 1'b1;
                d_imm = 3'd3;
                d_illegal = (EN_JUMPS == 0);
            end
            default: d_illegal = 1'b1;
        endcase
        // register indices beyond the implemented file (RV32E) are undecodable
        if ((d_wr && rd_i >= REG_N) || (d_use1 && rs1_i >= REG_N) || (d_use2 && rs2_i >= REG_N))
            d_illegal = 1'b1;
    end

    assign d_reg_wen = d_wr && (rd_f != 5'd0) && !d_illegal;

    // ID/EX register
    logic                  ex_valid, ex_illegal, ex_load, ex_branch, ex_jump;
    logic                  ex_a, ex_b, ex_mem_rw, ex_reg_wen;
    logic [2:0]            ex_imm, ex_f3;
    logic [3:0]            ex_alu;
    logic [1:0]            ex_wb;
    logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;

    // Branch resolution from EX contents and live comparator flags
    logic br_cond, taken, hazard;
    always_comb begin
        case (ex_f3)
            3'd0:       br_cond = i_br_eq;
            3'd1:       br_cond = !i_br_eq;
            3'd4, 3'd6: br_cond = i_br_lt;
            default:    br_cond = !i_br_lt;
        endcase
    end

    assign taken    = ex_valid && ((ex_branch && br_cond) || ex_jump);
    assign o_pc_sel = taken && !i_ex_stall;
    assign o_flush  = o_pc_sel;

    // Load-use: EX load writing a register the ID instruction reads
    assign hazard = (EN_HAZARD != 0) && i_inst_valid && ex_valid && ex_load && (ex_rd != '0) &&
                    ((d_use1 && (rs1_f[REG_ADDR_W-1:0] == ex_rd)) ||
                     (d_use2 && (rs2_f[REG_ADDR_W-1:0] == ex_rd)));

    // A taken redirect overrides the hazard: the ID instruction is consumed and dropped
    assign o_id_ready = !rst && i_inst_valid && !i_ex_stall && (o_pc_sel || !hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            ex_load    <= 1'b0;
            ex_branch  <= 1'b0;
            ex_jump    <= 1'b0;
            ex_a       <= 1'b0;
            ex_b       <= 1'b0;
            ex_mem_rw  <= 1'b0;
            ex_reg_wen <= 1'b0;
            ex_imm     <= 3'd0;
            ex_f3      <= 3'd0;
            ex_alu     <= 4'd0;
            ex_wb      <= 2'd0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
        end else if (!i_ex_stall) begin
            ex_valid   <= i_inst_valid && !hazard && !o_pc_sel;
            ex_illegal <= d_illegal;
            ex_load    <= d_load && !d_illegal;
            ex_branch  <= d_branch && !d_illegal;
            ex_jump    <= d_jump && !d_illegal;
            ex_a       <= d_a;
            ex_b       <= d_b;
            ex_mem_rw  <= d_mem_rw && !d_illegal;
            ex_reg_wen <= d_reg_wen;
            ex_imm     <= d_imm;
            ex_f3      <= f3;
            ex_alu     <= d_alu;
            ex_wb      <= d_wb;
            ex_rd      <= rd_f[REG_ADDR_W-1:0];
            ex_rs1     <= rs1_f[REG_ADDR_W-1:0];
            ex_rs2     <= rs2_f[REG_ADDR_W-1:0];
        end
    end

    assign o_ex_valid   = ex_valid;
    assign o_imm_sel    = ex_imm;
    assign o_br_un      = ex_branch && ex_f3[1];
    assign o_a_sel      = ex_a;
    assign o_b_sel      = ex_b;
    assign o_alu_sel    = ex_alu;
    assign o_mem_rw     = ex_valid && ex_mem_rw;
    assign o_reg_wen    = ex_valid && ex_reg_wen;
    assign o_wb_sel     = ex_wb;
    assign o_mem_funct3 = ex_f3;
    assign o_rd         = ex_rd;
    assign o_rs1        = ex_rs1;
    assign o_rs2        = ex_rs2;
    assign o_illegal    = ex_valid && ex_illegal;
endmodule

// File: tb/tb_rv32_pipe_controller.sv
// Directed bench for rv32_pipe_controller with hand-encoded RV32I instructions.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// All comparisons funnel through chk().
module tb_rv32_pipe_controller;
    logic        clk, rst;
    logic        i_inst_valid, i_ex_stall, i_br_eq, i_br_lt;
    logic [31:0] i_inst;
    logic        o_id_ready, o_ex_valid, o_pc_sel, o_flush, o_br_un, o_a_sel, o_b_sel;
    logic        o_mem_rw, o_reg_wen, o_illegal;
    logic [2:0]  o_imm_sel, o_mem_funct3;
    logic [3:0]  o_alu_sel;
    logic [1:0]  o_wb_sel;
    logic [4:0]  o_rd, o_rs1, o_rs2;

    localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] SUB3   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] LW5    = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD6   = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] SW5    = 32'h0050A223; // sw   x5,4(x1)
    localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD6Z  = 32'h00200333; // add  x6,x0,x2
    localparam logic [31:0] BEQ    = 32'h00208463; // beq  x1,x2,8
    localparam logic [31:0] BGEU   = 32'h0020F463; // bgeu x1,x2,8
    localparam logic [31:0] JAL5   = 32'h010002EF; // jal  x5,16
    localparam logic [31:0] JAL1   = 32'h010000EF; // jal  x1,16
    localparam logic [31:0] ILL    = 32'hFFFFFFFF; // undefined opcode
    localparam logic [31:0] SLTBAD = 32'h4020A1B3; // slt with funct7=0x20
    localparam logic [31:0] LUI7   = 32'h123453B7; // lui  x7,0x12345
    localparam logic [31:0] ADDX0  = 32'h00208033; // add  x0,x1,x2

    int n_tests = 0;
    int n_fail  = 0;

    rv32_pipe_controller dut (
        .clk(clk), .rst(rst),
        .i_inst_valid(i_inst_valid), .i_inst(i_inst), .o_id_ready(o_id_ready),
        .i_ex_stall(i_ex_stall), .i_br_eq(i_br_eq), .i_br_lt(i_br_lt),
        .o_ex_valid(o_ex_valid), .o_pc_sel(o_pc_sel), .o_flush(o_flush),
        .o_imm_sel(o_imm_sel), .o_br_un(o_br_un), .o_a_sel(o_a_sel), .o_b_sel(o_b_sel),
        .o_alu_sel(o_alu_sel), .o_mem_rw(o_mem_rw), .o_reg_wen(o_reg_wen),
        .o_wb_sel(o_wb_sel), .o_mem_funct3(o_mem_funct3),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_illegal(o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_inst_valid = 1'b0; i_inst = 32'h13;
        i_ex_stall = 1'b0; i_br_eq = 1'b0; i_br_lt = 1'b0;

        // reset: everything quiet, no accept even with a valid instruction
        #2 i_inst_valid = 1'b1; i_inst = ADD3; #1;
        chk("rst_ready", o_id_ready, 0);
        chk("rst_exv", o_ex_valid, 0);
        chk("rst_pcsel", o_pc_sel, 0);
        chk("rst_flush", o_flush, 0);
        chk("rst_wen", o_reg_wen, 0);
        tick();
        chk("rst_exv_edge", o_ex_valid, 0);
        rst = 1'b0; i_inst_valid = 1'b0; tick();

        // simple ALU ops
        i_inst_valid = 1'b1; i_inst = ADD3; #1;
        chk("add_ready", o_id_ready, 1);
        tick();
        chk("add_exv", o_ex_valid, 1);
        chk("add_alu", o_alu_sel, 0);
        chk("add_bsel", o_b_sel, 0);
        chk("add_wb", o_wb_sel, 1);
        chk("add_wen", o_reg_wen, 1);
        chk("add_rd", o_rd, 3);
        i_inst = SUB3; tick();
        chk("sub_alu", o_alu_sel, 1);
        i_inst_valid = 1'b0; tick();
        chk("idle_exv", o_ex_valid, 0);
        chk("idle_wen", o_reg_wen, 0);

        // load-use via rs1
        i_inst_valid = 1'b1; i_inst = LW5; tick();
        chk("lw_wb", o_wb_sel, 0);
        chk("lw_f3", o_mem_funct3, 2);
        chk("lw_wen", o_reg_wen, 1);
        chk("lw_bsel", o_b_sel, 1);
        i_inst = ADD6; #1;
        chk("lu_ready0", o_id_ready, 0);
        tick();
        chk("lu_bubble", o_ex_valid, 0);
        chk("lu_bubble_wen", o_reg_wen, 0);
        chk("lu_ready1", o_id_ready, 1);
        tick();
        chk("lu_issue", o_ex_valid, 1);
        chk("lu_rd", o_rd, 6);
        i_inst_valid = 1'b0; tick();

        // load-use via rs2 of a store
        i_inst_valid = 1'b1; i_inst = LW5; tick();
        i_inst = SW5; #1;
        chk("lus_ready0", o_id_ready, 0);
        tick();
        chk("lus_bubble", o_ex_valid, 0);
        tick();
        chk("sw_memrw", o_mem_rw, 1);
        chk("sw_wen", o_reg_wen, 0);
        chk("sw_imm", o_imm_sel, 1);
        i_inst_valid = 1'b0; tick();

        // load to x0 never stalls
        i_inst_valid = 1'b1; i_inst = LW0; tick();
        i_inst = ADD6Z; #1;
        chk("lw0_ready", o_id_ready, 1);
        tick();
        chk("lw0_next", o_ex_valid, 1);
        i_inst_valid = 1'b0; tick();

        // taken beq flushes the ID instruction
        i_inst_valid = 1'b1; i_inst = BEQ; tick();
        chk("beq_imm", o_imm_sel, 2);
        chk("beq_asel", o_a_sel, 1);
        chk("beq_wen", o_reg_wen, 0);
        i_br_eq = 1'b1; i_inst = ADD3; #1;
        chk("beq_pcsel", o_pc_sel, 1);
        chk("beq_flush", o_flush, 1);
        chk("beq_ready", o_id_ready, 1);
        tick();
        chk("beq_dropped", o_ex_valid, 0);
        chk("beq_pcsel_off", o_pc_sel, 0);
        i_inst_valid = 1'b0; i_br_eq = 1'b0; tick();

        // not-taken beq lets the next instruction through
        i_inst_valid = 1'b1; i_inst = BEQ; tick();
        i_inst = ADD3; #1;
        chk("beqnt_pcsel", o_pc_sel, 0);
        tick();
        chk("beqnt_next", o_ex_valid, 1);
        i_inst_valid = 1'b0; tick();

        // bgeu held by stall, resolves when stall drops
        i_inst_valid = 1'b1; i_inst = BGEU; tick();
        i_ex_stall = 1'b1; i_br_lt = 1'b0; i_inst = ADD3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bgeu_brun", o_br_un, 1);
            chk("bgeu_stall_pcsel", o_pc_sel, 0);
            chk("bgeu_stall_ready", o_id_ready, 0);
            tick();
        end
        chk("bgeu_held", o_ex_valid, 1);
        i_ex_stall = 1'b0; #1;
        chk("bgeu_pcsel", o_pc_sel, 1);
        chk("bgeu_flush", o_flush, 1);
        tick();
        chk("bgeu_dropped", o_ex_valid, 0);
        i_inst_valid = 1'b0; tick();

        // jump with a dependent ID instruction: flush wins, ready stays high
        i_inst_valid = 1'b1; i_inst = JAL5; tick();
        chk("jal_wb", o_wb_sel, 2);
        chk("jal_imm", o_imm_sel, 4);
        chk("jal_wen", o_reg_wen, 1);
        i_inst = ADD6; #1;
        chk("jdep_flush", o_flush, 1);
        chk("jdep_ready", o_id_ready, 1);
        tick();
        chk("jdep_bubble", o_ex_valid, 0);

        // illegal encodings and x0 writes
        i_inst = ILL; tick();
        chk("ill_flag", o_illegal, 1);
        chk("ill_exv", o_ex_valid, 1);
        chk("ill_wen", o_reg_wen, 0);
        chk("ill_pcsel", o_pc_sel, 0);
        i_inst = SLTBAD; tick();
        chk("sltbad_flag", o_illegal, 1);
        i_inst = LUI7; tick();
        chk("lui_flag", o_illegal, 0);
        chk("lui_alu", o_alu_sel, 10);
        chk("lui_imm", o_imm_sel, 3);
        i_inst = ADDX0; tick();
        chk("x0_exv", o_ex_valid, 1);
        chk("x0_wen", o_reg_wen, 0);
        i_inst_valid = 1'b0; tick();

        // reset while a taken jal sits in EX
        i_inst_valid = 1'b1; i_inst = JAL1; tick();
        i_inst_valid = 1'b0; #1;
        chk("jrst_pcsel_pre", o_pc_sel, 1);
        rst = 1'b1; #1;
        chk("jrst_pcsel", o_pc_sel, 0);
        chk("jrst_flush", o_flush, 0);
        chk("jrst_exv", o_ex_valid, 0);
        #2 rst = 1'b0;
        tick();
        chk("jrst_after_pcsel", o_pc_sel, 0);
        chk("jrst_after_exv", o_ex_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
